// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues in-order memory reads under a 2-slot credit,
// buffers returned words in a 2-entry queue for ID, and drops stale responses after a redirect.
module fetch_queue_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [11:0] branch_target,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_ir,
    output logic [11:0] if_npc,
    input  logic        id_ready,
    output logic        resp_err
);

    logic [11:0] fetch_pc;

    logic [31:0] q_ir [2];
    logic [11:0] q_pc [2];
    logic        q_rd;
    logic        q_wr;
    logic [1:0]  count;

    logic [11:0] af_addr [2];
    logic        af_rd;
    logic        af_wr;
    logic [1:0]  inflight;
    logic [1:0]  drop;
    logic        resp_err_q;

    logic        pop;
    logic        accept;
    logic        discard;
    logic        stray;
    logic [2:0]  occ;

    // Stale responses still occupy a credit until they come back, so drop counts as occupancy.
    always_comb begin
        pop      = (count != 2'd0) & id_ready & !rst;
        occ      = {1'b0, count} + {1'b0, inflight} + {1'b0, drop};
        imem_req = !rst & !pcsrc & (occ < (3'd2 + {2'b00, pop}));
        accept   = imem_rvalid & (drop == 2'd0) & (inflight != 2'd0);
        discard  = imem_rvalid & (drop != 2'd0);
        stray    = imem_rvalid & (drop == 2'd0) & (inflight == 2'd0);
    end

    assign imem_addr = fetch_pc;
    assign if_valid  = !rst & (count != 2'd0);
    assign if_ir     = if_valid ? q_ir[q_rd] : 32'd0;
    assign if_npc    = if_valid ? (q_pc[q_rd] + 12'd4) : 12'd0;
    assign resp_err  = resp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            q_rd       <= 1'b0;
            q_wr       <= 1'b0;
            count      <= 2'd0;
            af_rd      <= 1'b0;
            af_wr      <= 1'b0;
            inflight   <= 2'd0;
            drop       <= 2'd0;
            resp_err_q <= 1'b0;
        end else begin
            if (stray) begin
                resp_err_q <= 1'b1;
            end
            if (pcsrc) begin
                // Everything still outstanding at the memory becomes stale, including
                // responses already owed to an earlier redirect.
                fetch_pc <= branch_target;
                q_rd     <= 1'b0;
                q_wr     <= 1'b0;
                count    <= 2'd0;
                af_rd    <= 1'b0;
                af_wr    <= 1'b0;
                inflight <= 2'd0;
                drop     <= drop - 2'(discard) + inflight - 2'(accept);
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + 12'd4;
                    af_wr    <= ~af_wr;
                end
                if (accept) begin
                    af_rd <= ~af_rd;
                    q_wr  <= ~q_wr;
                end
                if (pop) begin
                    q_rd <= ~q_rd;
                end
                count    <= count + 2'(accept) - 2'(pop);
                inflight <= inflight + 2'(imem_req) - 2'(accept);
                if (discard) begin
                    drop <= drop - 2'd1;
                end
            end
        end
    end

    // Payload storage carries no reset; occupancy counters decide what is meaningful.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            af_addr[af_wr] <= fetch_pc;
        end
        if (accept) begin
            q_ir[q_wr] <= imem_rdata;
            q_pc[q_wr] <= af_addr[af_rd];
        end
    end

endmodule
